// File: rtl/ua_share_arbiter.sv
// Break-before-make arbiter for a shared analog pin bus: round-robin grant, settle delay, dead gap.
// Optional owner timeout with per-requester masking is enabled by defining UA_SHARE_TIMEOUT_EN.
module ua_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int DEAD_CYC    = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         sw_en,
    output logic                    ready,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    tmo
);

    localparam int OW   = $clog2(NREQ);
    localparam int CMAX = (SETTLE_CYC > DEAD_CYC) ? SETTLE_CYC : DEAD_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWN    = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [OW-1:0]   w_win;
    int              w_k;
    logic            w_on;

`ifdef UA_SHARE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   r_tcnt;
    logic [TW-1:0]   w_tcnt_nxt;
    logic [NREQ-1:0] r_mask;
    logic [NREQ-1:0] w_mask_set;
    logic            r_tmo;
    logic            w_tmo_nxt;

    assign w_elig = req & ~r_mask;
    assign tmo    = r_tmo;
`else
    assign w_elig = req;
    assign tmo    = 1'b0;
`endif

    // Round-robin pick: first eligible requester after the most recent owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_owner;
        w_k     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_k = int'(r_owner) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end else begin
                w_k = w_k;
            end
            if (!w_found && w_elig[w_k[OW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_k[OW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and counter reload logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
`ifdef UA_SHARE_TIMEOUT_EN
        w_tcnt_nxt  = r_tcnt;
        w_tmo_nxt   = 1'b0;
        w_mask_set  = {NREQ{1'b0}};
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SETTLE;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = CW'(SETTLE_CYC - 1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETTLE: begin
                if (!req[r_owner]) begin
                    w_state_nxt = DEAD;
                    w_cnt_nxt   = CW'(DEAD_CYC - 1);
                end else if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = OWN;
                    w_cnt_nxt   = {CW{1'b0}};
`ifdef UA_SHARE_TIMEOUT_EN
                    w_tcnt_nxt  = TW'(TIMEOUT_CYC - 1);
`endif
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            OWN: begin
                if (!req[r_owner]) begin
                    w_state_nxt = DEAD;
                    w_cnt_nxt   = CW'(DEAD_CYC - 1);
`ifdef UA_SHARE_TIMEOUT_EN
                end else if (r_tcnt == {TW{1'b0}}) begin
                    // Forced release: the owner stays masked until it lets go of req.
                    w_state_nxt         = DEAD;
                    w_cnt_nxt           = CW'(DEAD_CYC - 1);
                    w_tmo_nxt           = 1'b1;
                    w_mask_set[r_owner] = 1'b1;
                end else begin
                    w_tcnt_nxt  = r_tcnt - TW'(1);
                end
`else
                end else begin
                    w_state_nxt = OWN;
                end
`endif
            end
            DEAD: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // State, owner and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OW'(NREQ - 1);
            r_cnt   <= {CW{1'b0}};
`ifdef UA_SHARE_TIMEOUT_EN
            r_tcnt  <= {TW{1'b0}};
            r_mask  <= {NREQ{1'b0}};
            r_tmo   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef UA_SHARE_TIMEOUT_EN
            r_tcnt  <= w_tcnt_nxt;
            r_mask  <= (r_mask | w_mask_set) & req;
            r_tmo   <= w_tmo_nxt;
`endif
        end
    end

    assign w_on  = (r_state == SETTLE) || (r_state == OWN);
    assign gnt   = w_on ? (ONE << r_owner) : {NREQ{1'b0}};
    assign sw_en = gnt;
    assign ready = (r_state == OWN);
    assign busy  = (r_state != IDLE);
    assign owner = r_owner;

endmodule

// File: tb/tb_ua_share_arbiter.sv
// Scoreboarded bench for ua_share_arbiter: expected grants are queued by stimulus, popped by a monitor.
module tb_ua_share_arbiter;

    localparam int NREQ   = 4;
    localparam int SETTLE = 4;
    localparam int DEAD   = 2;
    localparam int TMOC   = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] sw_en;
    logic       ready;
    logic [1:0] owner;
    logic       busy;
    logic       tmo;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    ua_share_arbiter #(
        .NREQ(NREQ), .SETTLE_CYC(SETTLE), .DEAD_CYC(DEAD), .TIMEOUT_CYC(TMOC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sw_en(sw_en),
        .ready(ready), .owner(owner), .busy(busy), .tmo(tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(ready), 32'd1);
    endtask

    task automatic idle_out(input string name);
        int n;
        n = 0;
        req = 4'b0000;
        tick();
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: per-cycle grant properties plus scoreboard pop on every new grant.
    initial begin
        logic [3:0] pg;
        logic       pr;
        int         zr;
        int         sc;
        bit         had;
        int         e;
        pg = 4'b0000; pr = 1'b0; zr = 0; sc = 0; had = 1'b0;
        forever begin
            @(negedge clk);
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("sw_en_onehot", 32'($countones(sw_en) <= 1), 32'd1);
            check("sw_en_eq_gnt", 32'(sw_en), 32'(gnt));
`ifndef UA_SHARE_TIMEOUT_EN
            check("tmo_tied", 32'(tmo), 32'd0);
`endif
            if (rst) had = 1'b0;
            if (gnt != 4'b0000 && pg == 4'b0000) begin
                if (had) check("gnt_gap", 32'(zr >= DEAD + 1), 32'd1);
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", 32'(gnt), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_gnt", 32'(gnt), 32'd1 << e);
                    check("grant_owner", 32'(owner), 32'(e));
                end
                had = 1'b1;
                zr  = 0;
                sc  = 0;
            end else if (gnt != 4'b0000) begin
                sc++;
            end else begin
                zr++;
            end
            if (ready && !pr) check("settle_len", 32'(sc), 32'(SETTLE));
            pg = gnt;
            pr = ready;
        end
    end

    initial begin
        int ord[5];
        int n;
        ord = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req = 4'b0000;
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_sw_en", 32'(sw_en), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        check("rst_owner", 32'(owner), 32'd3);
        tick();
        rst = 1'b0;

        // Single requester: settle timing and dead-time release
        req = 4'b0001;
        exp_q.push_back(0);
        tick();
        check("A_gnt", 32'(gnt), 32'h1);
        check("A_ready_e0", 32'(ready), 32'd0);
        check("A_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        check("A_ready_e3", 32'(ready), 32'd0);
        check("A_gnt_e3", 32'(gnt), 32'h1);
        tick();
        check("A_ready_e4", 32'(ready), 32'd1);
        req = 4'b0000;
        tick();
        check("A_rel_gnt", 32'(gnt), 32'd0);
        check("A_rel_ready", 32'(ready), 32'd0);
        check("A_rel_busy", 32'(busy), 32'd1);
        tick();
        check("A_dead_busy", 32'(busy), 32'd1);
        tick();
        check("A_idle_busy", 32'(busy), 32'd0);

        // All requesting: round-robin order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) exp_q.push_back(ord[g]);
        for (int g = 0; g < 5; g++) begin
            wait_ready("B_ready");
            check("B_owner", 32'(owner), 32'(ord[g]));
            repeat (3) tick();
            req[ord[g]] = 1'b0;
            tick();
            check("B_drop_gnt", 32'(gnt), 32'd0);
            if (g == 4) req = 4'b0000;
            else        req[ord[g]] = 1'b1;
        end
        idle_out("B_idle");

        // Drop during SETTLE: ready never rises, DEAD lasts 2 cycles
        do_reset();
        req = 4'b0100;
        exp_q.push_back(2);
        tick();
        check("C_gnt", 32'(gnt), 32'h4);
        tick();
        check("C_ready_e1", 32'(ready), 32'd0);
        req = 4'b0000;
        tick();
        check("C_drop_gnt", 32'(gnt), 32'd0);
        check("C_drop_sw_en", 32'(sw_en), 32'd0);
        check("C_drop_ready", 32'(ready), 32'd0);
        check("C_drop_busy", 32'(busy), 32'd1);
        tick();
        check("C_dead_busy", 32'(busy), 32'd1);
        check("C_dead_ready", 32'(ready), 32'd0);
        tick();
        check("C_idle_busy", 32'(busy), 32'd0);
        check("C_idle_ready", 32'(ready), 32'd0);

        // Asynchronous reset while owner 1 holds the bus
        do_reset();
        req = 4'b0010;
        exp_q.push_back(1);
        wait_ready("D_ready");
        check("D_owner", 32'(owner), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("D_rst_gnt", 32'(gnt), 32'd0);
        check("D_rst_sw_en", 32'(sw_en), 32'd0);
        check("D_rst_ready", 32'(ready), 32'd0);
        check("D_rst_busy", 32'(busy), 32'd0);
        check("D_rst_owner", 32'(owner), 32'd3);
        #2;
        rst = 1'b0;
        exp_q.push_back(1);
        tick();
        check("D_regrant", 32'(gnt), 32'h2);
        idle_out("D_idle");

`ifdef UA_SHARE_TIMEOUT_EN
        // Forced release after TIMEOUT_CYC ready cycles, owner 0 masked afterwards
        do_reset();
        req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_ready("E_ready");
        n = 1;
        tick();
        while (ready && n < 100) begin
            n++;
            tick();
        end
        check("E_ready_cycles", 32'(n), 32'(TMOC));
        check("E_tmo", 32'(tmo), 32'd1);
        check("E_tmo_gnt", 32'(gnt), 32'd0);
        tick();
        check("E_tmo_pulse", 32'(tmo), 32'd0);
        wait_ready("E_ready2");
        check("E_owner2", 32'(owner), 32'd1);
        idle_out("E_idle");
`else
        // No timeout: an owner keeps the bus indefinitely
        do_reset();
        req = 4'b0001;
        exp_q.push_back(0);
        wait_ready("E_ready");
        repeat (80) tick();
        check("E_hold_gnt", 32'(gnt), 32'h1);
        check("E_hold_ready", 32'(ready), 32'd1);
        check("E_hold_tmo", 32'(tmo), 32'd0);
        idle_out("E_idle");
`endif

        repeat (2) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ua_share_arbiter.md
UA_SHARE_ARBITER -- requirements
Module: ua_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the analog pin bus; legal range 2..8.
REQ-002 Parameter SETTLE_CYC, default 4: cycles the switch is closed before the owner is told the bus is ready; legal range 1..255.
REQ-003 Parameter DEAD_CYC, default 2: break-before-make gap, in cycles, between releasing one owner and granting the next; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYC, default 64: maximum number of cycles an owner may hold READY before forced release; legal range 1..65535.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req  input  NREQ  per-requester level request; held high for as long as the requester wants the bus.
REQ-008 gnt  output  NREQ  one-hot or zero grant to the current owner.
REQ-009 sw_en  output  NREQ  one-hot or zero analog switch enable, equal to gnt in every cycle.
REQ-010 ready  output  1  high while the owner's switch has settled.
REQ-011 owner  output  ceil(log2 NREQ)  index of the current or most recent owner.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tmo  output  1  one-cycle pulse on forced release.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SETTLE, OWN and DEAD, and all outputs SHALL be decoded from registered state only.
REQ-015 In IDLE, on an edge where any unmasked req bit is high, the FSM SHALL latch the winner into owner and enter SETTLE, so gnt rises one cycle after req is sampled.
REQ-016 The winner SHALL be selected round-robin: search starts at owner+1 modulo NREQ and takes the first unmasked high req bit.
REQ-017 SETTLE SHALL assert gnt and sw_en for the owner with ready low, SHALL last exactly SETTLE_CYC cycles, and SHALL then enter OWN.
REQ-018 OWN SHALL assert gnt, sw_en and ready for the owner.
REQ-019 When req[owner] is sampled low in SETTLE or OWN, the FSM SHALL enter DEAD on that edge, and gnt, sw_en and ready SHALL all drop together.
REQ-020 DEAD SHALL hold gnt, sw_en and ready low for exactly DEAD_CYC cycles and then enter IDLE, so at least DEAD_CYC+1 cycles separate any two grants.
REQ-021 Changes on requests from non-owners SHALL have no effect while the FSM is outside IDLE.
REQ-022 At most one bit of gnt and of sw_en SHALL be high in any cycle.
REQ-023 The settle and dead counters SHALL be wide enough to hold their maximum value, and SHALL reload on every state entry without wrapping.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, gnt=0, sw_en=0, ready=0, busy=0, tmo=0, owner=NREQ-1, all counters 0 and the timeout mask cleared, including mid-SETTLE or mid-OWN.
REQ-025 On the first edge after rst deasserts, arbitration SHALL proceed as in REQ-015; with owner=NREQ-1, req[0] has first priority.

Configuration
REQ-026 With macro UA_SHARE_TIMEOUT_EN defined:
- a counter SHALL count cycles in OWN;
- when it reaches TIMEOUT_CYC, the FSM SHALL enter DEAD and pulse tmo for one cycle;
- that requester SHALL be masked from arbitration until its req is sampled low.
REQ-027 Without UA_SHARE_TIMEOUT_EN, no timeout counter or mask SHALL exist, tmo SHALL be tied 0, and an owner SHALL keep the bus indefinitely.

Verification
REQ-028 Defaults; req=0001 at edge 0 -> gnt=sw_en=0001 after edge 0, ready high after edge 4; req=0000 -> all outputs low, busy low 2 cycles later.
REQ-029 req=1111 held, each owner dropping req 3 cycles after ready -> grant order 0,1,2,3,0, with every gap between grants at least 3 cycles of zero gnt.
REQ-030 req[2] dropped during SETTLE (cycle 2) -> gnt clears on that edge, ready never rises, DEAD lasts 2 cycles.
REQ-031 rst pulsed during OWN with owner=1 -> gnt, sw_en and ready go 0 asynchronously before the next clk edge; owner reads NREQ-1 (3 at default).
REQ-032 UA_SHARE_TIMEOUT_EN with TIMEOUT_CYC=8; req=0011 held -> owner 0 forced off after 8 ready cycles with tmo=1 for one cycle; req[0] stays masked, so owner 1 is granted next.
REQ-033 A one-hot checker on gnt and sw_en, plus a check that sw_en equals gnt, SHALL run in every scenario with zero violations.
